// File: rtl/regfile_sb.sv
// regfile_sb -- multi-ported register file with a reservation scoreboard.
//
// Purpose:
//   DEPTH = 2**ADDR_W registers of DATA_W bits with one synchronous write
//   port and two combinational read ports. Each register also has a busy
//   bit. A reserve request marks a register as pending a future write, and
//   a write to that register clears the mark. The sticky err flag records
//   protocol violations: reserving a register that is already busy, or
//   writing a register that was never reserved.
//
// Parameters:
//   DATA_W   register width in bits (1..64)
//   ADDR_W   address width; DEPTH = 2**ADDR_W
//   ZERO_REG 1: register 0 reads as zero, ignores writes and reserves
//   BYPASS   1: same-cycle write data/busy-clear is forwarded to read ports
//
// Ports:
//   clk                        rising-edge clock
//   rst                        asynchronous active-high reset
//   EN                         global enable, gates every state update
//   write_en/addr/data         write port
//   read_addr_1/2              read port addresses
//   read_data_1/2              read port data (combinational)
//   rsv_en, rsv_addr           reserve request
//   rsv_ok                     1 when rsv_addr is not busy (combinational)
//   busy_1, busy_2             busy status of read_addr_1/2 (combinational)
//   err                        sticky protocol-error flag
module regfile_sb #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 3,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              EN,
    input  logic              write_en,
    input  logic [ADDR_W-1:0] write_addr,
    input  logic [DATA_W-1:0] write_data,
    input  logic [ADDR_W-1:0] read_addr_1,
    input  logic [ADDR_W-1:0] read_addr_2,
    output logic [DATA_W-1:0] read_data_1,
    output logic [DATA_W-1:0] read_data_2,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic              rsv_ok,
    output logic              busy_1,
    output logic              busy_2,
    output logic              err
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic              err_q;

    logic wr_zero;
    logic rsv_zero;
    logic wr_fire;
    logic rsv_fire;
    logic err_set;

    // Qualified requests: enabled, not aimed at a hardwired zero register,
    // and not during reset (so nothing is forwarded while rst is high).
    always_comb begin
        wr_zero  = (ZERO_REG != 0) && (write_addr == '0);
        rsv_zero = (ZERO_REG != 0) && (rsv_addr == '0);
        wr_fire  = EN && write_en && !wr_zero && !rst;
        rsv_fire = EN && rsv_en && !rsv_zero && !rst;
    end

    // A reserve to an address being written in the same cycle is legal:
    // the write retires the old reservation as the new one lands.
    always_comb begin
        err_set = 1'b0;
        if (rsv_fire && busy[rsv_addr] && !(wr_fire && (write_addr == rsv_addr)))
            err_set = 1'b1;
        if (wr_fire && !busy[write_addr])
            err_set = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++)
                regs[i] <= '0;
            busy  <= '0;
            err_q <= 1'b0;
        end else begin
            if (wr_fire)
                regs[write_addr] <= write_data;
            // Set is scheduled after clear so a same-address reserve wins.
            if (wr_fire)
                busy[write_addr] <= 1'b0;
            if (rsv_fire)
                busy[rsv_addr] <= 1'b1;
            if (err_set)
                err_q <= 1'b1;
        end
    end

    // Read port 1
    always_comb begin
        read_data_1 = regs[read_addr_1];
        busy_1      = busy[read_addr_1];
        if ((ZERO_REG != 0) && (read_addr_1 == '0)) begin
            read_data_1 = '0;
            busy_1      = 1'b0;
        end
        if ((BYPASS != 0) && wr_fire && (write_addr == read_addr_1)) begin
            read_data_1 = write_data;
            busy_1      = 1'b0;
        end
        if (rst) begin
            read_data_1 = '0;
            busy_1      = 1'b0;
        end
    end

    // Read port 2
    always_comb begin
        read_data_2 = regs[read_addr_2];
        busy_2      = busy[read_addr_2];
        if ((ZERO_REG != 0) && (read_addr_2 == '0)) begin
            read_data_2 = '0;
            busy_2      = 1'b0;
        end
        if ((BYPASS != 0) && wr_fire && (write_addr == read_addr_2)) begin
            read_data_2 = write_data;
            busy_2      = 1'b0;
        end
        if (rst) begin
            read_data_2 = '0;
            busy_2      = 1'b0;
        end
    end

    always_comb begin
        rsv_ok = rst ? 1'b1 : !busy[rsv_addr];
        err    = err_q;
    end

endmodule
